user_strm_arb: RTL
==================

// Module: user_strm_arb
// PURPOSE
//  Parametrised N-stream aggregator between the switch user stream ports and user logic. Host-to-user: round-robin
//  arbitrates NUM_STRM valid/ack streams onto one registered, channel-tagged port, with burst locking. User-to-host:
//  demultiplexes one tagged return stream into NUM_STRM registered per-channel outputs. Replaces fixed per-stream wiring.
// PARAMETERS
//  NUM_STRM    4   stream channels, 1..8
//  DATA_WIDTH  64  beat width, multiple of 64
//  BURST_LEN   16  max consecutive beats granted to one channel, >=1 (1 = pure round robin)
//  CHAN_W      localparam = max(1, clog2(NUM_STRM)), channel tag width
// PORTS
//  i_user_clk         in   1                    user clock; all logic on rising edge
//  i_rst              in   1                    synchronous, active-high reset
//  i_strm_data_valid  in   NUM_STRM             host->user per-channel valid
//  o_strm_ack         out  NUM_STRM             host->user per-channel ack (beat taken when valid&ack)
//  i_strm_data        in   NUM_STRM*DATA_WIDTH  host->user data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//  o_user_data_valid  out  1                    aggregated beat valid to user logic
//  i_user_ack         in   1                    user logic accepts aggregated beat
//  o_user_data        out  DATA_WIDTH           aggregated beat data
//  o_user_chan        out  CHAN_W               source channel of aggregated beat
//  i_user_data_valid  in   1                    user->host return beat valid
//  o_user_ack         out  1                    return beat accepted
//  i_user_data        in   DATA_WIDTH           return beat data
//  i_user_chan        in   CHAN_W               return beat destination channel
//  o_strm_data_valid  out  NUM_STRM             user->host per-channel valid
//  i_strm_ack         in   NUM_STRM             user->host per-channel ack
//  o_strm_data        out  NUM_STRM*DATA_WIDTH  user->host per-channel data
//  o_chan_err         out  1                    sticky: return beat addressed channel >= NUM_STRM
// BEHAVIOUR
//  Reset: all valids, data, o_user_chan, o_chan_err = 0; rr pointer = 0; burst count = 0; lock cleared;
//   o_strm_ack and o_user_ack forced 0 while i_rst=1. In-flight beats discarded, nothing acked in reset cycle.
//  Handshake: beat transfers on valid&ack in same cycle; valid, once high, holds with stable data until acked.
//  Forward load: out reg accepts when !o_user_data_valid | i_user_ack (full throughput, 1 beat/clk).
//  Grant (comb): if lock held, locked chan still valid, count<BURST_LEN -> locked chan; else first valid chan
//   scanning from (last_grant+1) mod NUM_STRM upward with wrap. o_strm_ack = onehot(grant) & accept & any valid.
//  Latency: input handshake at cycle t -> o_user_data_valid/data/chan at t+1.
//  Burst FSM: IDLE -> LOCK on first grant (count=1); LOCK: count++ per accepted beat of locked chan;
//   LOCK -> IDLE (pointer=locked chan) when count==BURST_LEN or locked chan drops valid at an accept slot.
//   Stall (out reg full, no i_user_ack): no grant, count and lock held.
//  Return path: o_user_ack = chan<NUM_STRM ? (!o_strm_data_valid[chan] | i_strm_ack[chan]) : 1.
//   Accepted beat loads channel register at t+1. Out-of-range chan: beat acked, dropped, o_chan_err=1 until reset.
//   Per-channel registers independent; simultaneous drain and reload of same channel allowed.
// CONFIGURATION
//  STRM_WORD_SWAP_EN defined: each 64-bit lane's 32-bit halves swapped on both paths ({d[31:0],d[63:32]}).
//  Not defined: data passes unmodified. Arbitration, tags and timing identical either way.
// TESTING
//  1 Reset: i_rst=1 with all valids high -> all acks 0, all outputs 0; release -> first grant chan0.
//  2 RR, BURST_LEN=1: chans 0..3 valid continuously, i_user_ack=1 -> o_user_chan 0,1,2,3,0,... one beat/clk.
//  3 Burst: BURST_LEN=4, chans 1,2 valid -> chan tags 1,1,1,1,2,2,2,2,1; chan1 drops after 2 beats -> switch to 2.
//  4 Backpressure: i_user_ack=0 for 5 clks -> o_user_data stable, no o_strm_ack, burst count frozen; no loss.
//  5 Return: chan=2 data 64'h0123456789ABCDEF -> o_strm_data chan2 same (89ABCDEF01234567 with swap) next clk;
//    chan2 i_strm_ack=0 -> second chan2 beat o_user_ack=0; chan3 beat still accepted.
//  6 Error: NUM_STRM=3, i_user_chan=3 -> o_user_ack=1, no output valid, o_chan_err=1 held until i_rst.

Source files
------------

// File: rtl/user_strm_arb.sv
// N-stream aggregator: round-robin host->user arbiter with burst locking, and a tag-driven
// user->host demultiplexer. Define STRM_WORD_SWAP_EN to swap 32-bit halves of every 64-bit lane.
module user_strm_arb #(
  parameter int unsigned NUM_STRM   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 16,
  localparam int unsigned CHAN_W    = (NUM_STRM > 1) ? $clog2(NUM_STRM) : 1
) (
  input  logic                           i_user_clk,
  input  logic                           i_rst,
  input  logic [NUM_STRM-1:0]            i_strm_data_valid,
  output logic [NUM_STRM-1:0]            o_strm_ack,
  input  logic [NUM_STRM*DATA_WIDTH-1:0] i_strm_data,
  output logic                           o_user_data_valid,
  input  logic                           i_user_ack,
  output logic [DATA_WIDTH-1:0]          o_user_data,
  output logic [CHAN_W-1:0]              o_user_chan,
  input  logic                           i_user_data_valid,
  output logic                           o_user_ack,
  input  logic [DATA_WIDTH-1:0]          i_user_data,
  input  logic [CHAN_W-1:0]              i_user_chan,
  output logic [NUM_STRM-1:0]            o_strm_data_valid,
  input  logic [NUM_STRM-1:0]            i_strm_ack,
  output logic [NUM_STRM*DATA_WIDTH-1:0] o_strm_data,
  output logic                           o_chan_err
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  function automatic logic [DATA_WIDTH-1:0] lane_xform(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
`ifdef STRM_WORD_SWAP_EN
    for (int unsigned l = 0; l < DATA_WIDTH / 64; l++) begin
      r[l*64 +: 64] = {d[l*64 +: 32], d[l*64+32 +: 32]};
    end
`endif
    return r;
  endfunction

  function automatic logic [CHAN_W-1:0] chan_inc(input logic [CHAN_W-1:0] c);
    return (32'(c) == NUM_STRM - 1) ? '0 : c + CHAN_W'(1);
  endfunction

  // Host-to-user arbiter and output register
  state_e                state_q, state_d;
  logic [CHAN_W-1:0]     lock_chan_q, lock_chan_d;
  logic [CHAN_W-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [CHAN_W-1:0]     fwd_chan_q, fwd_chan_d;

  logic                  accept, lock_vld, lock_hold, grant_vld;
  logic [CHAN_W-1:0]     grant, scan_start;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_STRM-1:0]   strm_ack;

  always_comb begin
    int unsigned pos;
    pos        = 0;
    accept     = !fwd_valid_q || i_user_ack;
    lock_vld   = 1'b0;
    for (int unsigned k = 0; k < NUM_STRM; k++) begin
      if (32'(lock_chan_q) == k) lock_vld = i_strm_data_valid[k];
    end
    lock_hold  = (state_q == StLock) && lock_vld && (32'(cnt_q) < BURST_LEN);
    // A finished or broken burst resumes the scan just past the channel that held the lock.
    scan_start = (state_q == StLock) ? chan_inc(lock_chan_q) : ptr_q;

    grant_vld = 1'b0;
    grant     = '0;
    if (lock_hold) begin
      grant_vld = 1'b1;
      grant     = lock_chan_q;
    end else begin
      for (int unsigned i = 0; i < NUM_STRM; i++) begin
        pos = 32'(scan_start) + i;
        if (pos >= NUM_STRM) pos = pos - NUM_STRM;
        for (int unsigned k = 0; k < NUM_STRM; k++) begin
          if (!grant_vld && (k == pos) && i_strm_data_valid[k]) begin
            grant_vld = 1'b1;
            grant     = CHAN_W'(k);
          end
        end
      end
    end

    sel_data = '0;
    strm_ack = '0;
    for (int unsigned k = 0; k < NUM_STRM; k++) begin
      if (32'(grant) == k) begin
        sel_data    = i_strm_data[k*DATA_WIDTH +: DATA_WIDTH];
        strm_ack[k] = !i_rst && accept && grant_vld;
      end
    end

    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    fwd_valid_d = fwd_valid_q;
    fwd_data_d  = fwd_data_q;
    fwd_chan_d  = fwd_chan_q;
    if (accept) begin
      fwd_valid_d = grant_vld;
      if (grant_vld) begin
        fwd_data_d = lane_xform(sel_data);
        fwd_chan_d = grant;
        if (lock_hold) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d     = StLock;
          lock_chan_d = grant;
          cnt_d       = CntW'(1);
        end
      end else if (state_q == StLock) begin
        state_d = StIdle;
        ptr_d   = chan_inc(lock_chan_q);
        cnt_d   = '0;
      end
    end
  end

  // User-to-host demultiplexer
  logic [NUM_STRM-1:0]            ret_valid_q, ret_valid_d;
  logic [NUM_STRM*DATA_WIDTH-1:0] ret_data_q, ret_data_d;
  logic                           chan_err_q, chan_err_d;
  logic                           in_range, ret_ack;

  always_comb begin
    in_range = 32'(i_user_chan) < NUM_STRM;
    // Out-of-range tags match no channel, so they are acked and dropped.
    ret_ack  = 1'b1;
    for (int unsigned k = 0; k < NUM_STRM; k++) begin
      if (32'(i_user_chan) == k) ret_ack = !ret_valid_q[k] || i_strm_ack[k];
    end
    ret_ack = ret_ack && !i_rst;

    ret_valid_d = ret_valid_q & ~i_strm_ack;
    ret_data_d  = ret_data_q;
    for (int unsigned k = 0; k < NUM_STRM; k++) begin
      if (i_user_data_valid && ret_ack && (32'(i_user_chan) == k)) begin
        ret_valid_d[k]                         = 1'b1;
        ret_data_d[k*DATA_WIDTH +: DATA_WIDTH] = lane_xform(i_user_data);
      end
    end
    chan_err_d = chan_err_q || (i_user_data_valid && !in_range);
  end

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      lock_chan_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      fwd_chan_q  <= '0;
      ret_valid_q <= '0;
      ret_data_q  <= '0;
      chan_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
      fwd_chan_q  <= fwd_chan_d;
      ret_valid_q <= ret_valid_d;
      ret_data_q  <= ret_data_d;
      chan_err_q  <= chan_err_d;
    end
  end

  assign o_strm_ack        = strm_ack;
  assign o_user_data_valid = fwd_valid_q;
  assign o_user_data       = fwd_data_q;
  assign o_user_chan       = fwd_chan_q;
  assign o_user_ack        = ret_ack;
  assign o_strm_data_valid = ret_valid_q;
  assign o_strm_data       = ret_data_q;
  assign o_chan_err        = chan_err_q;

endmodule
